reg_context_xfer: RTL and testbench

- Context save/restore engine for the R0-R7 register file.
- Save: reads registers through the register-file read port and stores them to consecutive memory words.
- Restore: reads consecutive memory words and writes them back through the register-file load port.
- Sits beside the datapath. Drives the register file and a simple ready-based memory port; the control FSM owns arbitration (asserts Start only when the datapath is quiescent).

---
 rtl/reg_context_xfer.sv | 136 +++++++++++++
 tb/tb_reg_context_xfer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_context_xfer.sv
// Context save/restore engine: streams R0..R(NREGS-1) to consecutive memory
// words (save) or streams memory words back into the register file (restore).
module reg_context_xfer #(
    parameter int NREGS = 8,
    parameter int IDX_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Mode,
    input  logic [15:0]      Base,
    output logic             Busy,
    output logic             Done,
    output logic [IDX_W-1:0] RF_SR,
    input  logic [15:0]      RF_SR_DATA,
    output logic             RF_LD,
    output logic [IDX_W-1:0] RF_DR,
    output logic [15:0]      RF_D,
    output logic [15:0]      MEM_ADDR,
    output logic [15:0]      MEM_WDATA,
    output logic             MEM_WE,
    output logic             MEM_RE,
    input  logic             MEM_RDY,
    input  logic [15:0]      MEM_RDATA
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_REQ,
        RD_REQ,
        RD_WB,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      base_q, base_d;
    logic             mode_q, mode_d;
    logic [15:0]      hold_q, hold_d;
    logic [15:0]      xferAddr;

    // Address arithmetic deliberately wraps modulo 2^16.
    assign xferAddr = base_q + 16'(idx_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            mode_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        mode_d    = mode_q;
        hold_d    = hold_q;
        Busy      = 1'b0;
        Done      = 1'b0;
        RF_SR     = '0;
        RF_LD     = 1'b0;
        RF_DR     = '0;
        RF_D      = '0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_WE    = 1'b0;
        MEM_RE    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    base_d  = Base;
                    mode_d  = Mode;
                    idx_d   = '0;
                    state_d = Mode ? RD_REQ : SAVE_REQ;
                end
            end
            SAVE_REQ: begin
                Busy      = 1'b1;
                RF_SR     = idx_q;
                MEM_WE    = 1'b1;
                MEM_ADDR  = xferAddr;
                MEM_WDATA = RF_SR_DATA;
                if (MEM_RDY) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RD_REQ: begin
                Busy     = 1'b1;
                MEM_RE   = 1'b1;
                MEM_ADDR = xferAddr;
                if (MEM_RDY) begin
                    hold_d  = MEM_RDATA;
                    state_d = RD_WB;
                end
            end
            RD_WB: begin
                // Gating with mode_q guarantees no register write can leak out of a save.
                Busy  = 1'b1;
                RF_LD = mode_q;
                RF_DR = idx_q;
                RF_D  = hold_q;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = RD_REQ;
                end
            end
            DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_context_xfer.sv
// Self-checking bench for reg_context_xfer: a transaction-queue model predicts
// every cycle's outputs, backed by directed scenarios with hand-computed pins.
module tb_reg_context_xfer;

    localparam int OP_WRITE = 0;
    localparam int OP_READ  = 1;
    localparam int OP_LOAD  = 2;
    localparam int OP_DONE  = 3;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [2:0]  idx;
    } op_t;

    logic        clk = 1'b0;
    logic        reset, start, mode, memRdy;
    logic [15:0] base;
    logic        busy, done, rfLd, memWe, memRe;
    logic [2:0]  rfSr, rfDr;
    logic [15:0] rfSrData, rfD, memAddr, memWdata, memRdata;

    logic [15:0] rf [0:7];
    logic [15:0] mem [0:65535];

    op_t  q[$];
    bit   checkEn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   negCnt = 0;
    int   startNeg = 0;
    int   doneCount = 0;
    int   lastDoneCycle = 0;
    int   ldCount = 0;
    int   holdCycles = 0;
    logic [58:0] expV, actV;

    always #5 clk = ~clk;

    assign rfSrData = rf[rfSr];
    assign memRdata = mem[memAddr];

    reg_context_xfer #(.NREGS(8), .IDX_W(3)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Mode(mode), .Base(base),
        .Busy(busy), .Done(done), .RF_SR(rfSr), .RF_SR_DATA(rfSrData),
        .RF_LD(rfLd), .RF_DR(rfDr), .RF_D(rfD), .MEM_ADDR(memAddr),
        .MEM_WDATA(memWdata), .MEM_WE(memWe), .MEM_RE(memRe),
        .MEM_RDY(memRdy), .MEM_RDATA(memRdata)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, negCnt, act, exp);
        end
    endtask

    // The queue head is the transaction the engine must be presenting this cycle;
    // an empty queue means the engine must be idle with every output low.
    always @(negedge clk) begin
        if (checkEn) begin
            negCnt++;
            expV = '0;
            if (q.size() > 0) begin
                case (q[0].kind)
                    OP_WRITE: expV = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, q[0].idx, 3'd0, 16'h0, q[0].addr, q[0].data};
                    OP_READ:  expV = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0, q[0].addr, 16'h0};
                    OP_LOAD:  expV = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, q[0].idx, q[0].data, 16'h0, 16'h0};
                    default:  expV = {1'b1, 1'b1, 57'h0};
                endcase
            end
            actV = {busy, done, rfLd, memWe, memRe, rfSr, rfDr, rfD, memAddr, memWdata};
            checkOutput("outputs", 64'(actV), 64'(expV));

            if (done) begin
                doneCount++;
                lastDoneCycle = negCnt - startNeg;
            end
            if (rfLd) ldCount++;
            if (memWe && memAddr == 16'h3004) holdCycles++;

            if (reset) begin
                q.delete();
            end else if (q.size() == 0) begin
                if (start) begin
                    startNeg = negCnt;
                    for (int i = 0; i < 8; i++) begin
                        if (!mode) begin
                            q.push_back('{OP_WRITE, 16'(base + 16'(i)), rf[i], 3'(i)});
                        end else begin
                            q.push_back('{OP_READ, 16'(base + 16'(i)), 16'h0, 3'(i)});
                            q.push_back('{OP_LOAD, 16'h0, mem[16'(base + 16'(i))], 3'(i)});
                        end
                    end
                    q.push_back('{OP_DONE, 16'h0, 16'h0, 3'd0});
                end
            end else if (q[0].kind == OP_WRITE || q[0].kind == OP_READ) begin
                if (memRdy) void'(q.pop_front());
            end else begin
                void'(q.pop_front());
            end
        end
    end

    // Drive one cycle of inputs; the bench's register file and memory commit
    // whatever the engine writes in that cycle.
    task automatic applyStimulus(input logic st, input logic md, input logic [15:0] bs,
                                 input logic rdy, input logic rst);
        start  = st;
        mode   = md;
        base   = bs;
        memRdy = rdy;
        reset  = rst;
        @(negedge clk);
        if (rfLd) rf[rfDr] = rfD;
        if (memWe && memRdy) mem[memAddr] = memWdata;
        @(posedge clk);
        #1;
    endtask

    task automatic runTransfer(input logic md, input logic [15:0] bs, input logic [15:0] stallAddr,
                               input int stallN, input int pulseAt);
        int   d0;
        int   n;
        int   left;
        logic rdy;
        d0   = doneCount;
        n    = 0;
        left = stallN;
        applyStimulus(1'b1, md, bs, 1'b1, 1'b0);
        while (doneCount == d0 && n < 100) begin
            rdy = 1'b1;
            if ((memWe || memRe) && memAddr == stallAddr && left > 0) begin
                rdy = 1'b0;
                left--;
            end
            applyStimulus(n == pulseAt, ~md, bs ^ 16'h5A5A, rdy, 1'b0);
            n++;
        end
        checkOutput("doneSeen", 64'(doneCount != d0), 64'd1);
    endtask

    initial begin
        int d0;
        int ld0;
        int h0;
        int n;
        logic        st, md, rdy, rst;
        logic [15:0] bs;

        start = 1'b0; mode = 1'b0; base = '0; memRdy = 1'b0; reset = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) rf[i] = 16'h1110 + 16'(i);

        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        checkEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("resetBusy", 64'(busy), 64'd0);

        // Plain save.
        ld0 = ldCount;
        runTransfer(1'b0, 16'h3000, 16'h0, 0, -1);
        checkOutput("saveDoneCycle", 64'(lastDoneCycle), 64'd9);
        checkOutput("saveMem0", 64'(mem[16'h3000]), 64'h1110);
        checkOutput("saveMem7", 64'(mem[16'h3007]), 64'h1117);
        checkOutput("saveNoLoad", 64'(ldCount - ld0), 64'd0);

        // Plain restore.
        for (int i = 0; i < 8; i++) begin
            mem[16'h4000 + 16'(i)] = 16'hA000 + 16'(i);
            rf[i] = 16'h0;
        end
        ld0 = ldCount;
        runTransfer(1'b1, 16'h4000, 16'h0, 0, -1);
        checkOutput("restoreDoneCycle", 64'(lastDoneCycle), 64'd17);
        checkOutput("restoreR0", 64'(rf[0]), 64'hA000);
        checkOutput("restoreR7", 64'(rf[7]), 64'hA007);
        checkOutput("restoreLoads", 64'(ldCount - ld0), 64'd8);

        // Save with three not-ready cycles on R4.
        for (int i = 0; i < 8; i++) begin
            rf[i] = 16'h1110 + 16'(i);
            mem[16'h3000 + 16'(i)] = 16'h0;
        end
        h0 = holdCycles;
        runTransfer(1'b0, 16'h3000, 16'h3004, 3, -1);
        checkOutput("stallDoneCycle", 64'(lastDoneCycle), 64'd12);
        checkOutput("stallHold", 64'(holdCycles - h0), 64'd4);
        checkOutput("stallMem4", 64'(mem[16'h3004]), 64'h1114);

        // Address wrap past 0xFFFF.
        runTransfer(1'b0, 16'hFFFE, 16'h0, 0, -1);
        checkOutput("wrapMemFFFE", 64'(mem[16'hFFFE]), 64'h1110);
        checkOutput("wrapMem0001", 64'(mem[16'h0001]), 64'h1113);
        checkOutput("wrapMem0005", 64'(mem[16'h0005]), 64'h1117);

        // Reset in the middle of a restore, right after R3 is written back.
        for (int i = 0; i < 8; i++) rf[i] = 16'h5550 + 16'(i);
        ld0 = ldCount;
        applyStimulus(1'b1, 1'b1, 16'h4000, 1'b1, 1'b0);
        n = 0;
        while (ldCount - ld0 < 4 && n < 100) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("reachR3", 64'(ldCount - ld0), 64'd4);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortNoLoad", 64'(ldCount - ld0), 64'd4);
        checkOutput("abortR3", 64'(rf[3]), 64'hA003);
        checkOutput("abortR4", 64'(rf[4]), 64'h5554);
        checkOutput("abortR7", 64'(rf[7]), 64'h5557);
        runTransfer(1'b1, 16'h4000, 16'h0, 0, -1);
        checkOutput("rerunDoneCycle", 64'(lastDoneCycle), 64'd17);
        checkOutput("rerunR4", 64'(rf[4]), 64'hA004);

        // Start pulsed mid-transfer with another Base/Mode must be ignored.
        for (int i = 0; i < 8; i++) rf[i] = 16'h2220 + 16'(i);
        d0 = doneCount;
        runTransfer(1'b0, 16'h5000, 16'h0, 0, 3);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 16'h6000, 1'b1, 1'b0);
        checkOutput("singleDone", 64'(doneCount - d0), 64'd1);
        checkOutput("busyMem7", 64'(mem[16'h5007]), 64'h2227);

        // Randomized traffic, including wrap-prone bases and occasional resets.
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            st  = !rst && ($urandom_range(0, 5) == 0);
            md  = 1'($urandom_range(0, 1));
            bs  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            applyStimulus(st, md, bs, rdy, rst);
        end
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        checkOutput("finalIdle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
